// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - registered ALU with iterative shifts and shift-add multiply
// Results are held behind a valid/ready handshake; one operation in flight at a time.
module alu_iter #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b0011;

  localparam bit           MUL_OK  = (MUL_EN != 0);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [3:0]       op_q;
  logic [SHW:0]     cnt_q;
  logic             zero_q, overflow_q, illegal_q;

  logic [WIDTH-1:0] sum, diff, res_d, sh_d, acc_d;
  logic             ovf_d, ill_d, is_shift, is_mul;
  logic [SHW-1:0]   shamt;

  assign shamt    = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign is_mul   = MUL_OK && (op == OP_MUL);

  // Single-cycle evaluation straight from the input operands; shifts by 0 pass a through.
  always_comb begin
    sum   = a + b;
    diff  = a - b;
    res_d = '0;
    ovf_d = 1'b0;
    ill_d = 1'b0;
    case (op)
      OP_ADD: begin
        res_d = sum;
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:                res_d = a ^ b;
      OP_AND:                res_d = a & b;
      OP_OR:                 res_d = a | b;
      OP_SLT:                res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:               res_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: res_d = a;
      OP_MUL:                ill_d = !MUL_OK;
      default:               ill_d = 1'b1;
    endcase
  end

  always_comb begin
    sh_d = a_q;
    case (op_q)
      OP_SLL:  sh_d = {a_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_d = {1'b0, a_q[WIDTH-1:1]};
      OP_SRA:  sh_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: sh_d = a_q;
    endcase
    acc_d = acc_q + (b_q[0] ? a_q : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            acc_q <= '0;
            if (is_shift && (shamt != '0)) begin
              state_q <= S_BUSY;
              cnt_q   <= {1'b0, shamt};
            end else if (is_mul) begin
              state_q <= S_BUSY;
              cnt_q   <= CNT_MUL;
            end else begin
              state_q    <= S_DONE;
              result_q   <= res_d;
              zero_q     <= (res_d == '0);
              overflow_q <= ovf_d;
              illegal_q  <= ill_d;
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (op_q == OP_MUL) begin
            acc_q <= acc_d;
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
          end else begin
            a_q <= sh_d;
          end
          if (cnt_q == CNT_ONE) begin
            state_q    <= S_DONE;
            result_q   <= (op_q == OP_MUL) ? acc_d : sh_d;
            zero_q     <= (((op_q == OP_MUL) ? acc_d : sh_d) == '0);
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed vector bench for alu_iter
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid1 = 1'b0;
  logic        out_ready = 1'b0, out_ready1 = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        in_ready, out_valid, zero, overflow, illegal;
  logic [31:0] result;
  logic        in_ready1, out_valid1, zero1, overflow1, illegal1;
  logic [31:0] result1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal));

  alu_iter #(.WIDTH(32), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .zero(zero1), .overflow(overflow1), .illegal(illegal1));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        z;
    logic        ovf;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one op on the main DUT, wait for out_valid, sample, then handshake.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop,
                        output logic [31:0] r, output logic z, output logic o,
                        output logic il, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    r = result; z = zero; o = overflow; il = illegal;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic z, o, il;
    int lat;
    int k;

    vecs[0]  = '{32'h7FFF_FFFF, 32'h1,         4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{32'h8000_0000, 32'hFFFF_FFE4, 4'b1101, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 5};
    vecs[2]  = '{32'h0000_1234, 32'h0,         4'b0111, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{32'h0000_FFFF, 32'h0001_0001, 4'b0011, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h1,         4'b1000, 32'h1,         1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h1,         4'b1001, 32'h0,         1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{32'h1234_5678, 32'h9,         4'b1111, 32'h0,         1'b1, 1'b0, 1'b1, 1};
    vecs[7]  = '{32'h8000_0000, 32'h1,         4'b0110, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{32'h0000_F0F0, 32'h0000_FF00, 4'b0100, 32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{32'hFFFF_0000, 32'h1234_5678, 4'b0000, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{32'h0000_000F, 32'h0000_00F0, 4'b0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{32'h8000_0000, 32'h0000_001F, 4'b0101, 32'h1,         1'b0, 1'b0, 1'b0, 32};
    vecs[12] = '{32'hFFFF_FFFF, 32'h1,         4'b0010, 32'h0,         1'b1, 1'b0, 1'b0, 1};
    vecs[13] = '{32'h0000_0007, 32'h6,         4'b0011, 32'h0000_002A, 1'b0, 1'b0, 1'b0, 33};
    vecs[14] = '{32'h0000_0001, 32'h0000_0021, 4'b0111, 32'h2,         1'b0, 1'b0, 1'b0, 2};

    // reset values
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, r, z, o, il, lat);
      check($sformatf("v%0d_result", i), {32'd0, r}, {32'd0, vecs[i].res});
      check($sformatf("v%0d_zero", i), {63'd0, z}, {63'd0, vecs[i].z});
      check($sformatf("v%0d_overflow", i), {63'd0, o}, {63'd0, vecs[i].ovf});
      check($sformatf("v%0d_illegal", i), {63'd0, il}, {63'd0, vecs[i].ill});
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end
    check("hold_after_handshake", {32'd0, result}, 64'h2);
    check("idle_out_valid", {63'd0, out_valid}, 64'd0);

    // SUB 5-5 with out_ready held low: result must stay put
    @(negedge clk);
    a = 32'd5; b = 32'd5; op = 4'b0110; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("sub_hold%0d_valid", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("sub_hold%0d_result", c), {32'd0, result}, 64'd0);
      check($sformatf("sub_hold%0d_zero", c), {63'd0, zero}, 64'd1);
      check($sformatf("sub_hold%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("sub_idle_in_ready", {63'd0, in_ready}, 64'd1);
    check("sub_idle_out_valid", {63'd0, out_valid}, 64'd0);

    // SRA shamt=4: four busy cycles, then result
    a = 32'h8000_0000; b = 32'hFFFF_FFE4; op = 4'b1101; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("sra_busy%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
      check($sformatf("sra_busy%0d_out_valid", c), {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end
    check("sra_done_valid", {63'd0, out_valid}, 64'd1);
    check("sra_done_result", {32'd0, result}, 64'hF800_0000);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // MUL on the MUL_EN=0 instance is illegal
    a = 32'h0000_FFFF; b = 32'h0001_0001; op = 4'b0011; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("nomul_valid", {63'd0, out_valid1}, 64'd1);
    check("nomul_illegal", {63'd0, illegal1}, 64'd1);
    check("nomul_result", {32'd0, result1}, 64'd0);
    check("nomul_zero", {63'd0, zero1}, 64'd1);
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;

    // async reset in the middle of a multiply
    a = 32'h0000_FFFF; b = 32'h0001_0001; op = 4'b0011; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (k = 1; k < 10; k++) @(negedge clk);
    check("mul_mid_busy", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    check("arst_no_stale_output", {63'd0, out_valid}, 64'd0);
    run_op(32'd2, 32'd3, 4'b0010, r, z, o, il, lat);
    check("post_rst_add_result", {32'd0, r}, 64'd5);
    check("post_rst_add_latency", 64'(lat), 64'd1);
    check("post_rst_add_zero", {63'd0, z}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
